// File: rtl/table_background_draw.sv
// Pool-table background renderer: rail, cushion, cloth and six pockets, plus a
// frame-timed rail flash. BG_RGB is registered, one cycle behind pixelX/pixelY.

module table_background_pocket #(
  parameter int CX = 0,
  parameter int CY = 0,
  parameter int R  = 14
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hit
);
  localparam logic [10:0] CX11 = 11'(CX);
  localparam logic [10:0] CY11 = 11'(CY);
  localparam logic [22:0] R2   = 23'(R * R);

  logic [10:0] dx, dy;
  logic [22:0] d2;

  always_comb begin
    dx  = (x >= CX11) ? (x - CX11) : (CX11 - x);
    dy  = (y >= CY11) ? (y - CY11) : (CY11 - y);
    d2  = 23'(dx) * 23'(dx) + 23'(dy) * 23'(dy);
    hit = (d2 <= R2);
  end
endmodule

module table_background_draw #(
  parameter int          X_FRAME_SIZE  = 639,
  parameter int          Y_FRAME_SIZE  = 479,
  parameter int          INNER_FRAME   = 25,
  parameter int          OUTER_FRAME   = 32,
  parameter int          POCKET_RADIUS = 14,
  parameter int          FLASH_FRAMES  = 60,
  parameter int          BLINK_PERIOD  = 8,
  parameter logic [7:0]  FLASH_COLOR   = 8'hFF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        flashReq,
  input  logic [1:0]  clothSel,
  output logic [7:0]  BG_RGB,
  output logic        flashActive
);
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int NUM_POCKETS = 6;

  localparam logic [10:0] XF     = 11'(X_FRAME_SIZE);
  localparam logic [10:0] YF     = 11'(Y_FRAME_SIZE);
  localparam logic [10:0] IN_LO  = 11'(INNER_FRAME);
  localparam logic [10:0] IN_XHI = 11'(X_FRAME_SIZE - INNER_FRAME);
  localparam logic [10:0] IN_YHI = 11'(Y_FRAME_SIZE - INNER_FRAME);
  localparam logic [10:0] OUT_LO  = 11'(OUTER_FRAME);
  localparam logic [10:0] OUT_XHI = 11'(X_FRAME_SIZE - OUTER_FRAME);
  localparam logic [10:0] OUT_YHI = 11'(Y_FRAME_SIZE - OUTER_FRAME);

  typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   frame_cnt, frame_nxt;
  logic [BW-1:0]   blink_cnt, blink_nxt;
  logic            phase, phase_nxt;
  logic [1:0]      cloth_q;
  logic [NUM_POCKETS-1:0] pocket_hit;
  logic [7:0]      color;
  logic            in_rail, in_cushion, off_screen;

  // Pocket centres: columns left/middle/right, rows top/bottom.
  for (genvar i = 0; i < NUM_POCKETS; i++) begin : g_pocket
    localparam int PCX = (i % 3 == 0) ? OUTER_FRAME :
                         (i % 3 == 1) ? (X_FRAME_SIZE / 2) : (X_FRAME_SIZE - OUTER_FRAME);
    localparam int PCY = (i < 3) ? OUTER_FRAME : (Y_FRAME_SIZE - OUTER_FRAME);
    table_background_pocket #(.CX(PCX), .CY(PCY), .R(POCKET_RADIUS)) u_pocket (
      .x  (pixelX),
      .y  (pixelY),
      .hit(pocket_hit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      cloth_q     <= 2'd0;
      BG_RGB      <= 8'hFF;
      flashActive <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_nxt;
      blink_cnt   <= blink_nxt;
      phase       <= phase_nxt;
      BG_RGB      <= color;
      flashActive <= (state_nxt == FLASH);
      if (startOfFrame) cloth_q <= clothSel;
    end
  end

  // A flashReq always wins over a coincident startOfFrame tick.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    blink_nxt = blink_cnt;
    phase_nxt = phase;
    if (flashReq) begin
      state_nxt = FLASH;
      frame_nxt = '0;
      blink_nxt = '0;
      phase_nxt = 1'b1;
    end else if (state == FLASH && startOfFrame) begin
      if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
        state_nxt = IDLE;
        phase_nxt = 1'b0;
      end else begin
        frame_nxt = frame_cnt + 1'b1;
        if (blink_cnt == BW'(BLINK_PERIOD - 1)) begin
          blink_nxt = '0;
          phase_nxt = ~phase;
        end else begin
          blink_nxt = blink_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    off_screen = (pixelX > XF) || (pixelY > YF);
    in_rail    = (pixelX <= IN_LO) || (pixelY <= IN_LO) ||
                 (pixelX >= IN_XHI) || (pixelY >= IN_YHI);
    in_cushion = (pixelX <= OUT_LO) || (pixelY <= OUT_LO) ||
                 (pixelX >= OUT_XHI) || (pixelY >= OUT_YHI);
    if (off_screen || (|pocket_hit)) color = 8'h00;
    else if (in_rail)                color = (state == FLASH && phase) ? FLASH_COLOR : 8'hFC;
    else if (in_cushion)             color = 8'h28;
    else begin
      case (cloth_q)
        2'd0:    color = 8'h58;
        2'd1:    color = 8'h0B;
        2'd2:    color = 8'h80;
        default: color = 8'h6D;
      endcase
    end
  end
endmodule

// File: tb/tb_table_background_draw.sv
// Randomised scoreboard bench for table_background_draw against a geometric /
// tick-counting reference model.

module tb_table_background_draw;
  localparam int XF = 639, YF = 479, IF = 25, OF = 32, PR = 14;
  localparam int FFR = 6, BP = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        startOfFrame = 1'b0, flashReq = 1'b0;
  logic [1:0]  clothSel = 2'd0;
  logic [7:0]  BG_RGB;
  logic        flashActive;

  always #5 clk = ~clk;

  table_background_draw #(
    .X_FRAME_SIZE(XF), .Y_FRAME_SIZE(YF), .INNER_FRAME(IF), .OUTER_FRAME(OF),
    .POCKET_RADIUS(PR), .FLASH_FRAMES(FFR), .BLINK_PERIOD(BP), .FLASH_COLOR(8'hFF)
  ) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .flashReq(flashReq), .clothSel(clothSel),
    .BG_RGB(BG_RGB), .flashActive(flashActive)
  );

  logic [8:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Model: flash is "active" with m_k frame ticks elapsed since the request.
  bit         m_active = 0;
  int         m_k = 0;
  logic [1:0] m_cloth = 2'd0;

  function automatic logic [7:0] ref_color(int x, int y, bit flash_on, logic [1:0] cl);
    int cxs[3];
    int cys[2];
    logic [7:0] cloth_tab[4];
    cxs = '{OF, XF / 2, XF - OF};
    cys = '{OF, YF - OF};
    cloth_tab = '{8'h58, 8'h0B, 8'h80, 8'h6D};
    if (x > XF || y > YF) return 8'h00;
    foreach (cxs[i]) foreach (cys[j])
      if ((x - cxs[i]) * (x - cxs[i]) + (y - cys[j]) * (y - cys[j]) <= PR * PR) return 8'h00;
    if (x <= IF || y <= IF || x >= XF - IF || y >= YF - IF) return flash_on ? 8'hFF : 8'hFC;
    if (x <= OF || y <= OF || x >= XF - OF || y >= YF - OF) return 8'h28;
    return cloth_tab[cl];
  endfunction

  task automatic step(input logic rst_n, input int x, input int y,
                      input logic sof, input logic req, input logic [1:0] sel);
    logic [7:0] e_bg;
    @(negedge clk);
    resetN = rst_n; pixelX = 11'(x); pixelY = 11'(y);
    startOfFrame = sof; flashReq = req; clothSel = sel;
    if (!rst_n) begin
      e_bg = 8'hFF; m_active = 0; m_k = 0; m_cloth = 2'd0;
    end else begin
      e_bg = ref_color(x, y, m_active && ((m_k / BP) % 2 == 0), m_cloth);
      if (sof) m_cloth = sel;
      if (req) begin
        m_active = 1; m_k = 0;
      end else if (m_active && sof) begin
        m_k++;
        if (m_k == FFR) m_active = 0;
      end
    end
    exp_q.push_back({m_active, e_bg});
  endtask

  task automatic tick_frames(input int n, input int x, input int y);
    for (int t = 0; t < n; t++) begin
      repeat (2) step(1, x, y, 0, 0, 2'd0);
      step(1, x, y, 1, 0, 2'd0);
    end
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (BG_RGB !== e[7:0]) begin
          n_bad++;
          $display("FAIL bg_rgb cyc=%0d x=%0d y=%0d got=%h exp=%h", cyc, pixelX, pixelY, BG_RGB, e[7:0]);
        end
        n_cmp++;
        if (flashActive !== e[8]) begin
          n_bad++;
          $display("FAIL flash_active cyc=%0d got=%b exp=%b", cyc, flashActive, e[8]);
        end
      end
    end
  end

  initial begin : driver
    int rx[9];
    int ry[9];
    rx = '{10, 28, 100, 32, 319, 319, 319, 700, 639};
    ry = '{200, 200, 100, 32, 20, 40, 60, 10, 479};

    repeat (3) step(0, $urandom_range(0, 2047), $urandom_range(0, 2047), 0, 0, 2'd0);
    step(1, 100, 100, 0, 0, 2'd0);
    step(1, 100, 100, 0, 0, 2'd0);

    foreach (rx[i]) step(1, rx[i], ry[i], 0, 0, 2'd0);

    // Cloth latch: mid-frame change must not show until after a startOfFrame.
    for (int s = 1; s < 4; s++) begin
      repeat (3) step(1, 100, 100, 0, 0, 2'(s));
      step(1, 100, 100, 1, 0, 2'(s));
      repeat (2) step(1, 100, 100, 0, 0, 2'(s));
    end
    step(1, 100, 100, 1, 0, 2'd0);

    // Full flash sequence on the rail.
    step(1, 10, 200, 0, 1, 2'd0);
    tick_frames(7, 10, 200);

    // Restart colliding with the 3rd tick, then a full run.
    step(1, 10, 200, 0, 1, 2'd0);
    tick_frames(2, 10, 200);
    repeat (2) step(1, 10, 200, 0, 0, 2'd0);
    step(1, 10, 200, 1, 1, 2'd0);
    tick_frames(7, 10, 200);

    // Reset mid-flash.
    step(1, 10, 200, 0, 1, 2'd0);
    tick_frames(1, 10, 200);
    step(0, 10, 200, 0, 0, 2'd0);
    step(1, 10, 200, 0, 0, 2'd0);
    step(1, 10, 200, 1, 0, 2'd0);

    for (int n = 0; n < 4000; n++) begin
      int x, y;
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 2047); y = $urandom_range(0, 2047);
      end else begin
        x = $urandom_range(0, 660); y = $urandom_range(0, 500);
      end
      step(($urandom_range(0, 299) != 0), x, y, ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 79) == 0), 2'($urandom_range(0, 3)));
    end

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/table_background_draw.md
Name: table_background_draw

Overview:
- Parametrised background renderer for the pool-table VGA screen: rail, cushion, cloth and six pockets, with a selectable cloth colour and a timed rail-flash effect triggered by game events.
- Sits in the VGA drawing chain beside the object drawers and feeds the background input of the object mux.
- Output is registered with one cycle of latency from pixelX/pixelY.

Parameters:
- X_FRAME_SIZE, 639, last visible X coordinate.
- Y_FRAME_SIZE, 479, last visible Y coordinate.
- INNER_FRAME, 25, rail width in pixels, measured from each screen edge.
- OUTER_FRAME, 32, outer edge of the cushion band; must be greater than INNER_FRAME.
- POCKET_RADIUS, 14, pocket radius in pixels.
- FLASH_FRAMES, 60, length of one flash sequence in frames (≥1).
- BLINK_PERIOD, 8, frames per blink phase (≥1).
- FLASH_COLOR, 8'hFF, rail colour during the flash "on" phase.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  synchronous active-low reset.
- pixelX  in  11  current pixel X.
- pixelY  in  11  current pixel Y.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- flashReq  in  1  one-cycle pulse that starts or restarts a flash sequence.
- clothSel  in  2  cloth colour: 0 green 8'h58, 1 blue 8'h0B, 2 red 8'h80, 3 grey 8'h6D.
- BG_RGB  out  8  {R[2:0],G[2:0],B[1:0]}, registered.
- flashActive  out  1  high while a flash sequence is running.

Behaviour:
- Clock and reset: one clock, clk. resetN is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: BG_RGB=8'hFF, flashActive=0, latched cloth select=0, state=IDLE, frameCnt=0, blinkCnt=0, phase=0.
- Latency: BG_RGB at edge N+1 is the colour of (pixelX,pixelY) sampled at edge N. Colour is computed from state registers as they stand before that edge.
- Region priority (first match wins):
  - Off-screen: pixelX>X_FRAME_SIZE or pixelY>Y_FRAME_SIZE -> 8'h00.
  - Pocket -> 8'h00. A pixel is in a pocket if dx²+dy² ≤ POCKET_RADIUS² for any of six centres:
    - (OUTER_FRAME, OUTER_FRAME), (X_FRAME_SIZE/2, OUTER_FRAME), (X_FRAME_SIZE-OUTER_FRAME, OUTER_FRAME);
    - the same three X values at Y_FRAME_SIZE-OUTER_FRAME.
    - dx and dy are 11-bit unsigned absolute differences; squares and sum are 23 bits, unsigned compare; X_FRAME_SIZE/2 truncates.
  - Rail: X≤INNER_FRAME or Y≤INNER_FRAME or X≥X_FRAME_SIZE-INNER_FRAME or Y≥Y_FRAME_SIZE-INNER_FRAME -> FLASH_COLOR when state=FLASH and phase=1, else 8'hFC.
  - Cushion: the same four tests with OUTER_FRAME -> 8'h28.
  - Otherwise cloth colour from the latched select.
- Cloth select latch: clothSel is captured only on cycles where startOfFrame=1. A mid-frame change never alters the current frame.
- Flash FSM, IDLE / FLASH:
  - IDLE, flashReq=1 -> FLASH; frameCnt=0, blinkCnt=0, phase=1.
  - FLASH, flashReq=1 -> restart with the same loads; the startOfFrame in that cycle is ignored.
  - FLASH, startOfFrame=1, no flashReq:
    - If frameCnt==FLASH_FRAMES-1 -> IDLE, phase=0.
    - Else frameCnt++. If blinkCnt==BLINK_PERIOD-1 then blinkCnt=0 and phase toggles, else blinkCnt++.
  - flashActive is registered and equals (state==FLASH), so it rises one edge after the flashReq edge.
  - Counters sized by $clog2 of their parameter, minimum 1 bit.
- Reset asserted mid-flash returns to IDLE at the next edge. BG_RGB shows 8'hFF during reset.

Test Plan:
- Reset: hold resetN=0 for 3 clk with arbitrary pixels -> BG_RGB=8'hFF, flashActive=0. Release, drive (100,100) -> next cycle BG_RGB=8'h58.
- Region map, no flash, one cycle latency each:
  - (10,200) -> 8'hFC; (28,200) -> 8'h28; (100,100) -> 8'h58;
  - (32,32) -> 8'h00; (319,20) -> 8'h00 (pocket overrides rail); (319,40) -> 8'h00;
  - (319,60) -> 8'h58; (700,10) -> 8'h00; (639,479) -> 8'hFC.
- Cloth latch: set clothSel=1 mid-frame -> (100,100) stays 8'h58 until the next startOfFrame, then 8'h0B. Repeat for 2 -> 8'h80 and 3 -> 8'h6D.
- Flash timing with FLASH_FRAMES=6, BLINK_PERIOD=2, pixel held at (10,200):
  - flashReq -> flashActive=1 next edge.
  - Rail 8'hFF for the frames before the 2nd tick, 8'hFC until the 4th tick, then 8'hFF.
  - At the 6th tick -> IDLE; rail 8'hFC, flashActive=0.
- Restart and collision:
  - flashReq at the 3rd frame tick, same cycle as startOfFrame -> counters reload, phase=1; the sequence then runs a full 6 further ticks.
  - Reset asserted mid-flash -> IDLE; flashActive=0 after the edge.
